// File: rtl/pavana_xbar_pkg.sv
// Shared types, constants and the round-robin pick helper for the
// pavana slave-port arbiter.
package pavana_xbar_pkg;

  localparam int MNUM_W      = 2;
  localparam int NUM_MASTERS = 4;

  localparam logic CMD_RD = 1'b0;
  localparam logic CMD_WR = 1'b1;

  typedef struct packed {
    logic              valid;
    logic [MNUM_W-1:0] idx;
  } rr_pick_t;

  // First set bit of req_vec at or above ptr, wrapping modulo NUM_MASTERS.
  // Iterates from the farthest offset down so the nearest one wins.
  function automatic rr_pick_t rr_pick(input logic [NUM_MASTERS-1:0] req_vec,
                                       input logic [MNUM_W-1:0]      ptr);
    rr_pick_t          res;
    logic [MNUM_W-1:0] cand;
    res = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      cand = ptr + MNUM_W'(i);
      if (req_vec[cand]) begin
        res.valid = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/pavana_slave_port_arb_fifo.sv
// Small synchronous FIFO, B bits wide and 2**W entries deep. Used to remember
// which master issued each outstanding read so responses can be routed back.
// Push while full and pop while empty are ignored.
module pavana_slave_port_arb_fifo #(
  parameter int B = 2,
  parameter int W = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push,
  input  logic [B-1:0] push_data,
  input  logic         pop,
  output logic [B-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int DEPTH = 1 << W;

  logic [B-1:0] mem [DEPTH];
  logic [W-1:0] wr_ptr;
  logic [W-1:0] rd_ptr;
  logic [W:0]   count;
  logic         do_push;
  logic         do_pop;

  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign full     = (count == (W+1)'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/pavana_slave_port_arb.sv
// 4:1 round-robin concentrator in front of a single req/ack/resp slave.
// Read responses are steered back to the issuing master via a routing FIFO.
// Optional build macro PAVANA_ARB_LOCK_EN: the last granted master keeps
// priority for up to BURST_LEN consecutive transfers while it stays eligible.
module pavana_slave_port_arb
  import pavana_xbar_pkg::*;
#(
  parameter int RESP_FIFO_ORDER = 2,
  parameter int BURST_LEN       = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        master_0_req,
  input  logic [31:0] master_0_addr,
  input  logic        master_0_cmd,
  input  logic [31:0] master_0_wdata,
  output logic        master_0_ack,
  output logic [31:0] master_0_rdata,
  output logic        master_0_resp,
  input  logic        master_1_req,
  input  logic [31:0] master_1_addr,
  input  logic        master_1_cmd,
  input  logic [31:0] master_1_wdata,
  output logic        master_1_ack,
  output logic [31:0] master_1_rdata,
  output logic        master_1_resp,
  input  logic        master_2_req,
  input  logic [31:0] master_2_addr,
  input  logic        master_2_cmd,
  input  logic [31:0] master_2_wdata,
  output logic        master_2_ack,
  output logic [31:0] master_2_rdata,
  output logic        master_2_resp,
  input  logic        master_3_req,
  input  logic [31:0] master_3_addr,
  input  logic        master_3_cmd,
  input  logic [31:0] master_3_wdata,
  output logic        master_3_ack,
  output logic [31:0] master_3_rdata,
  output logic        master_3_resp,
  output logic        slave_req,
  output logic [31:0] slave_addr,
  output logic        slave_cmd,
  output logic [31:0] slave_wdata,
  input  logic        slave_ack,
  input  logic [31:0] slave_rdata,
  input  logic        slave_resp,
  output logic        resp_orphan_o
);

  if (BURST_LEN < 1 || BURST_LEN > 15) begin : g_bad_burst_len
    $error("BURST_LEN must be in 1..15");
  end

  logic [NUM_MASTERS-1:0] req_vec;
  logic [NUM_MASTERS-1:0] cmd_vec;
  logic [NUM_MASTERS-1:0] elig;
  logic [31:0]            addr_arr  [NUM_MASTERS];
  logic [31:0]            wdata_arr [NUM_MASTERS];
  logic [MNUM_W-1:0]      rr_ptr;
  rr_pick_t               pick;
  logic                   xfer;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [MNUM_W-1:0]      fifo_head;
  logic                   resp_hit;

  assign req_vec      = {master_3_req, master_2_req, master_1_req, master_0_req};
  assign cmd_vec      = {master_3_cmd, master_2_cmd, master_1_cmd, master_0_cmd};
  assign addr_arr[0]  = master_0_addr;
  assign addr_arr[1]  = master_1_addr;
  assign addr_arr[2]  = master_2_addr;
  assign addr_arr[3]  = master_3_addr;
  assign wdata_arr[0] = master_0_wdata;
  assign wdata_arr[1] = master_1_wdata;
  assign wdata_arr[2] = master_2_wdata;
  assign wdata_arr[3] = master_3_wdata;

  // Reads are held off while the routing FIFO is full; writes never are.
  // Forcing eligibility low in reset silences every request-side output.
  assign elig = rst_i ? '0 : (req_vec & (cmd_vec | {NUM_MASTERS{~fifo_full}}));

`ifdef PAVANA_ARB_LOCK_EN
  logic [3:0]        lock_cnt;
  logic [3:0]        lock_cnt_nxt;
  logic [MNUM_W-1:0] lock_mst;
  logic              lock_act;
  logic              lock_keep;
  logic              lock_drop;

  assign lock_act     = (lock_cnt != 4'd0);
  assign lock_keep    = lock_act & elig[lock_mst];
  assign lock_drop    = lock_act & ~elig[lock_mst];
  assign lock_cnt_nxt = lock_keep ? (lock_cnt + 4'd1) : 4'd1;

  // Locked master wins outright; if it has dropped, scanning resumes after it.
  always_comb begin
    pick = rr_pick(elig, lock_drop ? (lock_mst + 2'd1) : rr_ptr);
    if (lock_keep) begin
      pick.valid = 1'b1;
      pick.idx   = lock_mst;
    end
  end

  // Pointer advances only when a lock ends: burst exhausted or master dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr   <= '0;
      lock_cnt <= '0;
      lock_mst <= '0;
    end else if (xfer) begin
      if (lock_cnt_nxt == 4'(BURST_LEN)) begin
        rr_ptr   <= pick.idx + 2'd1;
        lock_cnt <= '0;
      end else begin
        if (lock_drop) rr_ptr <= lock_mst + 2'd1;
        lock_mst <= pick.idx;
        lock_cnt <= lock_cnt_nxt;
      end
    end else if (lock_drop) begin
      rr_ptr   <= lock_mst + 2'd1;
      lock_cnt <= '0;
    end
  end
`else
  // Plain round robin starting from rr_ptr.
  always_comb begin
    pick = rr_pick(elig, rr_ptr);
  end

  // Every transfer moves the pointer just past the master that was served.
  always_ff @(posedge clk_i) begin
    if (rst_i)     rr_ptr <= '0;
    else if (xfer) rr_ptr <= pick.idx + 2'd1;
  end
`endif

  assign slave_req   = pick.valid;
  assign slave_addr  = pick.valid ? addr_arr[pick.idx]  : '0;
  assign slave_cmd   = pick.valid & cmd_vec[pick.idx];
  assign slave_wdata = pick.valid ? wdata_arr[pick.idx] : '0;
  assign xfer        = pick.valid & slave_ack;

  assign master_0_ack = xfer & (pick.idx == 2'd0);
  assign master_1_ack = xfer & (pick.idx == 2'd1);
  assign master_2_ack = xfer & (pick.idx == 2'd2);
  assign master_3_ack = xfer & (pick.idx == 2'd3);

  pavana_slave_port_arb_fifo #(
    .B (MNUM_W),
    .W (RESP_FIFO_ORDER)
  ) u_route_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push      (xfer & (slave_cmd == CMD_RD)),
    .push_data (pick.idx),
    .pop       (resp_hit),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // A response with nothing outstanding is flagged and otherwise dropped.
  assign resp_hit      = slave_resp & ~fifo_empty & ~rst_i;
  assign resp_orphan_o = slave_resp & fifo_empty & ~rst_i;

  assign master_0_resp = resp_hit & (fifo_head == 2'd0);
  assign master_1_resp = resp_hit & (fifo_head == 2'd1);
  assign master_2_resp = resp_hit & (fifo_head == 2'd2);
  assign master_3_resp = resp_hit & (fifo_head == 2'd3);

  assign master_0_rdata = slave_rdata;
  assign master_1_rdata = slave_rdata;
  assign master_2_rdata = slave_rdata;
  assign master_3_rdata = slave_rdata;

endmodule

// File: tb/tb_pavana_slave_port_arb.sv
// Bench for pavana_slave_port_arb: directed scenarios followed by random
// traffic, all cycles compared against a queue-based reference model.
module tb_pavana_slave_port_arb;

  localparam int DEPTH = 4;
  localparam int BURST = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        m_req [4];
  logic        m_cmd [4];
  logic [31:0] m_addr[4];
  logic [31:0] m_wd  [4];
  logic        s_ack, s_resp;
  logic [31:0] s_rdata;

  logic        ack0, ack1, ack2, ack3, rsp0, rsp1, rsp2, rsp3;
  logic [31:0] rd0, rd1, rd2, rd3;
  logic        slave_req, slave_cmd, orphan;
  logic [31:0] slave_addr, slave_wdata;

  int n_chk = 0;
  int n_fail = 0;

  // model state
  int m_ptr = 0;
  int q[$];
  int lk_cnt = 0;
  int lk_m = 0;
  bit last_xfer;
  int last_g;

  // samples taken each checked cycle
  logic [3:0]  obs_ack, obs_resp;
  logic        obs_orphan, obs_sreq;
  logic [31:0] obs_addr, obs_rdata1;

  always #5 clk_i = ~clk_i;

  pavana_slave_port_arb dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .master_0_req(m_req[0]), .master_0_addr(m_addr[0]), .master_0_cmd(m_cmd[0]), .master_0_wdata(m_wd[0]),
    .master_0_ack(ack0), .master_0_rdata(rd0), .master_0_resp(rsp0),
    .master_1_req(m_req[1]), .master_1_addr(m_addr[1]), .master_1_cmd(m_cmd[1]), .master_1_wdata(m_wd[1]),
    .master_1_ack(ack1), .master_1_rdata(rd1), .master_1_resp(rsp1),
    .master_2_req(m_req[2]), .master_2_addr(m_addr[2]), .master_2_cmd(m_cmd[2]), .master_2_wdata(m_wd[2]),
    .master_2_ack(ack2), .master_2_rdata(rd2), .master_2_resp(rsp2),
    .master_3_req(m_req[3]), .master_3_addr(m_addr[3]), .master_3_cmd(m_cmd[3]), .master_3_wdata(m_wd[3]),
    .master_3_ack(ack3), .master_3_rdata(rd3), .master_3_resp(rsp3),
    .slave_req(slave_req), .slave_addr(slave_addr), .slave_cmd(slave_cmd), .slave_wdata(slave_wdata),
    .slave_ack(s_ack), .slave_rdata(s_rdata), .slave_resp(s_resp),
    .resp_orphan_o(orphan)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic set_m(input int n, input bit req, input bit cmd, input logic [31:0] addr,
                       input logic [31:0] wd);
    m_req[n] = req; m_cmd[n] = cmd; m_addr[n] = addr; m_wd[n] = wd;
  endtask

  task automatic idle_all();
    for (int n = 0; n < 4; n++) set_m(n, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // One clock: compare DUT against the model at the falling edge, then
  // advance the model with the inputs the DUT sees at the next rising edge.
  task automatic step();
    bit [3:0] el;
    bit       gv, xfer;
    int       g, base, nc;
    logic [31:0] rd[4];
    logic        rs[4];
    logic        ak[4];
    @(negedge clk_i);
    rd = '{rd0, rd1, rd2, rd3};
    rs = '{rsp0, rsp1, rsp2, rsp3};
    ak = '{ack0, ack1, ack2, ack3};
    obs_ack    = {ack3, ack2, ack1, ack0};
    obs_resp   = {rsp3, rsp2, rsp1, rsp0};
    obs_orphan = orphan;
    obs_sreq   = slave_req;
    obs_addr   = slave_addr;
    obs_rdata1 = rd1;

    el = '0;
    for (int n = 0; n < 4; n++)
      el[n] = !rst_i && m_req[n] && (m_cmd[n] || q.size() < DEPTH);
    gv = 1'b0; g = 0; base = m_ptr;
`ifdef PAVANA_ARB_LOCK_EN
    if (lk_cnt > 0) begin
      if (el[lk_m]) begin gv = 1'b1; g = lk_m; end
      else base = (lk_m + 1) % 4;
    end
`endif
    if (!gv)
      for (int k = 0; k < 4; k++)
        if (el[(base + k) % 4]) begin gv = 1'b1; g = (base + k) % 4; break; end
    xfer = gv && s_ack;

    chk("slave_req", {31'b0, slave_req}, {31'b0, gv});
    chk("slave_addr", slave_addr, gv ? m_addr[g] : 32'h0);
    chk("slave_cmd", {31'b0, slave_cmd}, {31'b0, gv && m_cmd[g]});
    chk("slave_wdata", slave_wdata, gv ? m_wd[g] : 32'h0);
    for (int n = 0; n < 4; n++) begin
      chk($sformatf("ack%0d", n), {31'b0, ak[n]}, {31'b0, xfer && g == n});
      chk($sformatf("resp%0d", n), {31'b0, rs[n]},
          {31'b0, !rst_i && s_resp && q.size() > 0 && q[0] == n});
      chk($sformatf("rdata%0d", n), rd[n], s_rdata);
    end
    chk("orphan", {31'b0, orphan}, {31'b0, !rst_i && s_resp && q.size() == 0});

    last_xfer = xfer; last_g = g;
    if (rst_i) begin
      q.delete(); m_ptr = 0; lk_cnt = 0; lk_m = 0;
    end else begin
      if (s_resp && q.size() > 0) void'(q.pop_front());
      if (xfer && !m_cmd[g]) q.push_back(g);
`ifdef PAVANA_ARB_LOCK_EN
      if (xfer) begin
        nc = (lk_cnt > 0 && g == lk_m) ? lk_cnt + 1 : 1;
        if (lk_cnt > 0 && g != lk_m) m_ptr = (lk_m + 1) % 4;
        if (nc == BURST) begin m_ptr = (g + 1) % 4; lk_cnt = 0; end
        else begin lk_cnt = nc; lk_m = g; end
      end else if (lk_cnt > 0 && !el[lk_m]) begin
        m_ptr = (lk_m + 1) % 4; lk_cnt = 0;
      end
`else
      nc = 0;
      if (xfer) m_ptr = (g + 1) % 4;
`endif
    end
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    logic [3:0] seq[9];
    rst_i = 1'b1; s_ack = 1'b1; s_resp = 1'b1; s_rdata = 32'h1234_5678;
    for (int n = 0; n < 4; n++) set_m(n, 1'b1, 1'b1, 32'h40 * n, 32'h0);

    // reset gating
    step();
    chk("rst_ack", {28'b0, obs_ack}, 32'h0);
    chk("rst_resp", {28'b0, obs_resp}, 32'h0);
    chk("rst_orphan", {31'b0, obs_orphan}, 32'h0);
    chk("rst_sreq", {31'b0, obs_sreq}, 32'h0);
    rst_i = 1'b0; s_resp = 1'b0; idle_all();

    // single write from master 2
    set_m(2, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
    step();
    chk("m2_ack", {28'b0, obs_ack}, 32'h4);
    chk("m2_addr", obs_addr, 32'h10);
    for (int n = 0; n < 4; n++) set_m(n, 1'b1, 1'b1, 32'h100 + n, 32'h200 + n);
    step();
    chk("ptr3_grant", {28'b0, obs_ack}, 32'h8);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("rr_seq", {28'b0, obs_ack}, 32'(1 << (k % 4)));
    end
    idle_all();

    // fill the routing FIFO from master 1
    set_m(1, 1'b1, 1'b0, 32'h500, 32'h0);
    repeat (4) begin step(); chk("fill_ack", {28'b0, obs_ack}, 32'h2); end
    set_m(3, 1'b1, 1'b1, 32'h300, 32'h7);
    step();
    chk("full_wr_ok", {28'b0, obs_ack}, 32'h8);
    set_m(3, 1'b0, 1'b1, 32'h0, 32'h0);
    s_resp = 1'b1; s_rdata = 32'hA5A5_A5A5;
    step();
    chk("full_resp", {28'b0, obs_resp}, 32'h2);
    chk("full_rdata", obs_rdata1, 32'hA5A5_A5A5);
    chk("full_blk", {28'b0, obs_ack}, 32'h0);
    s_resp = 1'b0;
    step();
    chk("unblk", {28'b0, obs_ack}, 32'h2);
    idle_all(); s_resp = 1'b1;
    repeat (4) begin step(); chk("drain1", {28'b0, obs_resp}, 32'h2); end
    step();
    chk("drain_orphan", {31'b0, obs_orphan}, 32'h1);
    chk("drain_orphan_resp", {28'b0, obs_resp}, 32'h0);
    s_resp = 1'b0;

    // ordered routing 0,3,0
    set_m(0, 1'b1, 1'b0, 32'h1, 32'h0); step(); chk("o_ack0", {28'b0, obs_ack}, 32'h1);
    idle_all(); set_m(3, 1'b1, 1'b0, 32'h2, 32'h0); step(); chk("o_ack3", {28'b0, obs_ack}, 32'h8);
    idle_all(); set_m(0, 1'b1, 1'b0, 32'h3, 32'h0); step(); chk("o_ack0b", {28'b0, obs_ack}, 32'h1);
    idle_all(); s_resp = 1'b1;
    step(); chk("o_resp0", {28'b0, obs_resp}, 32'h1);
    step(); chk("o_resp3", {28'b0, obs_resp}, 32'h8);
    step(); chk("o_resp0b", {28'b0, obs_resp}, 32'h1);
    s_resp = 1'b0;

    // push and pop in one cycle
    set_m(2, 1'b1, 1'b0, 32'h4, 32'h0); step(); idle_all();
    set_m(1, 1'b1, 1'b0, 32'h5, 32'h0); s_resp = 1'b1;
    step();
    chk("pp_resp", {28'b0, obs_resp}, 32'h4);
    chk("pp_ack", {28'b0, obs_ack}, 32'h2);
    idle_all();
    step(); chk("pp_resp1", {28'b0, obs_resp}, 32'h2);
    step(); chk("pp_orphan", {31'b0, obs_orphan}, 32'h1);
    s_resp = 1'b0;

    // reset discards outstanding reads
    set_m(2, 1'b1, 1'b0, 32'h6, 32'h0); step(); step(); idle_all();
    rst_i = 1'b1; step(); rst_i = 1'b0;
    s_resp = 1'b1;
    step(); chk("rst_orph1", {31'b0, obs_orphan}, 32'h1); chk("rst_orph1_resp", {28'b0, obs_resp}, 32'h0);
    step(); chk("rst_orph2", {31'b0, obs_orphan}, 32'h1);
    s_resp = 1'b0;

    // two masters streaming writes from a fresh reset
    rst_i = 1'b1; step(); rst_i = 1'b0;
    set_m(0, 1'b1, 1'b1, 32'h7, 32'h0); set_m(1, 1'b1, 1'b1, 32'h8, 32'h0);
`ifdef PAVANA_ARB_LOCK_EN
    seq = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h2, 4'h2, 4'h2, 4'h2, 4'h1};
`else
    seq = '{4'h1, 4'h2, 4'h1, 4'h2, 4'h1, 4'h2, 4'h1, 4'h2, 4'h1};
`endif
    for (int k = 0; k < 9; k++) begin
      step();
      chk("burst_seq", {28'b0, obs_ack}, {28'b0, seq[k]});
    end
    idle_all();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      rst_i   = ($urandom_range(0, 249) == 0);
      s_ack   = ($urandom_range(0, 3) != 0);
      s_resp  = ($urandom_range(0, 2) == 0);
      s_rdata = $urandom;
      for (int n = 0; n < 4; n++)
        if (!m_req[n] && $urandom_range(0, 1) == 1)
          set_m(n, 1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom);
      step();
      if (last_xfer) m_req[last_g] = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
